// File: rtl/zstr_arb_pri.sv
`default_nettype none
// ============================================================================
// Module      : zstr_arb_pri
// Description : Combinational rotating priority encoder. Returns the index
//               of the first set request bit, scanning start, start+1, ...
//               RN-1, 0, ..., start-1 (modulo RN, RN need not be a power
//               of two).
// Ports       : req   [RN-1:0]  request vector
//               start [RNL-1:0] first index to examine (must be < RN)
//               idx   [RNL-1:0] winning index (0 when no request)
//               any             at least one request set
// Revision    : 1.0 - initial release
// ============================================================================
module zstr_arb_pri #(
    parameter int RN  = 2,
    parameter int RNL = $clog2(RN)
) (
    input  logic [RN-1:0]  req,
    input  logic [RNL-1:0] start,
    output logic [RNL-1:0] idx,
    output logic           any
);

    int w_j;

    // Scan from the farthest offset down to offset 0 so that the candidate
    // closest to start is the last one written and therefore wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        w_j = 0;
        for (int k = RN - 1; k >= 0; k--) begin
            w_j = int'(start) + k;
            if (w_j >= RN) begin
                w_j = w_j - RN;
            end
            if (req[w_j[RNL-1:0]]) begin
                idx = w_j[RNL-1:0];
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/zstr_arb.sv
`default_nettype none
// ============================================================================
// Module      : zstr_arb
// Description : Shares one zstr sink between RN zstr sources. A grant is
//               registered and held until the granted source completes a
//               transfer (vld & ack) or withdraws its request, so vld is
//               never dropped by the arbiter while a transfer is pending.
//               vld/bus/ack are passed through combinationally for the
//               granted port.
// Config      : ZSTR_ARB_RR_EN defined   -> round-robin (pointer advances
//                                           past each transferring source)
//               ZSTR_ARB_RR_EN undefined -> fixed priority, index 0 highest
// Ports       : z_clk   clock
//               z_rst   asynchronous reset, active-high
//               zi_vld  [RN]     per-source valid
//               zi_bus  [RN*BW]  per-source bus, source i at [i*BW +: BW]
//               zi_ack  [RN]     per-source acknowledge
//               zo_vld           shared sink valid
//               zo_bus  [BW]     shared sink bus
//               zo_ack           shared sink acknowledge
//               zo_gnt  [RNL]    current grant index
// Revision    : 1.0 - initial release
// ============================================================================
module zstr_arb #(
    parameter int BW  = 8,
    parameter int RN  = 2,
    parameter int RNL = $clog2(RN)
) (
    input  logic             z_clk,
    input  logic             z_rst,
    input  logic [RN-1:0]    zi_vld,
    input  logic [RN*BW-1:0] zi_bus,
    output logic [RN-1:0]    zi_ack,
    output logic             zo_vld,
    output logic [BW-1:0]    zo_bus,
    input  logic             zo_ack,
    output logic [RNL-1:0]   zo_gnt
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic           r_st;
    logic           w_st_nxt;
    logic [RNL-1:0] r_gnt;
    logic [RNL-1:0] w_gnt_nxt;
    logic [RNL-1:0] w_start;
    logic [RNL-1:0] w_win;
    logic           w_any;
    logic           w_cur_vld;
    logic [BW-1:0]  w_cur_bus;
    logic           w_xfer;

`ifdef ZSTR_ARB_RR_EN
    logic [RNL-1:0] r_ptr;
    logic [RNL-1:0] w_ptr_nxt;
    logic [RNL-1:0] w_gnt_inc;

    assign w_gnt_inc = (r_gnt == RNL'(RN - 1)) ? '0 : r_gnt + 1'b1;
`endif

    // Select the granted source's valid and bus.
    always_comb begin
        w_cur_vld = 1'b0;
        w_cur_bus = zi_bus[BW-1:0];
        for (int i = 0; i < RN; i++) begin
            if (r_gnt == RNL'(i)) begin
                w_cur_vld = zi_vld[i];
                w_cur_bus = zi_bus[i*BW +: BW];
            end
        end
    end

    assign zo_vld = (r_st == ST_GRANT) && w_cur_vld;
    assign zo_bus = w_cur_bus;
    assign zo_gnt = r_gnt;
    assign w_xfer = zo_vld && zo_ack;

    // Only the granted source sees ack, and only while its vld is presented.
    always_comb begin
        zi_ack = '0;
        for (int i = 0; i < RN; i++) begin
            if (r_gnt == RNL'(i)) begin
                zi_ack[i] = zo_vld && zo_ack;
            end
        end
    end

    zstr_arb_pri #(
        .RN  (RN),
        .RNL (RNL)
    ) u_pri (
        .req   (zi_vld),
        .start (w_start),
        .idx   (w_win),
        .any   (w_any)
    );

    always_comb begin
        w_st_nxt  = r_st;
        w_gnt_nxt = r_gnt;
`ifdef ZSTR_ARB_RR_EN
        w_ptr_nxt = r_ptr;
        w_start   = r_ptr;
`else
        w_start   = '0;
`endif
        case (r_st)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt = w_win;
                    w_st_nxt  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_xfer) begin
                    // The transferring source is still requesting, so the
                    // rearbitration is never empty; starting just past it
                    // gives it lowest priority.
`ifdef ZSTR_ARB_RR_EN
                    w_start   = w_gnt_inc;
                    w_ptr_nxt = w_gnt_inc;
`endif
                    if (w_any) begin
                        w_gnt_nxt = w_win;
                    end else begin
                        w_st_nxt = ST_IDLE;
                    end
                end else if (!w_cur_vld) begin
                    // Granted source withdrew before transferring.
                    if (w_any) begin
                        w_gnt_nxt = w_win;
                    end else begin
                        w_st_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_st_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            r_st  <= ST_IDLE;
            r_gnt <= '0;
`ifdef ZSTR_ARB_RR_EN
            r_ptr <= '0;
`endif
        end else begin
            r_st  <= w_st_nxt;
            r_gnt <= w_gnt_nxt;
`ifdef ZSTR_ARB_RR_EN
            r_ptr <= w_ptr_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
